// File: rtl/spike_gen_sequencer.sv
// Time-unit driven sweep over 2**Ngens programmable periodic spike generators.
// Define SPIKE_GEN_OVERRUN_CNT_EN to count (saturating) time pulses dropped mid-sweep.
module spike_gen_sequencer #(
  parameter int Ngens   = 8,
  parameter int Nperiod = 16,
  parameter int Ntag    = 11,
  parameter int Nct     = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                time_unit_pulse,
  input  logic [Ngens-1:0]    gens_used,
  input  logic [2**Ngens-1:0] gens_en,
  input  logic [Ngens-1:0]    prog_gen_idx,
  input  logic [Nperiod-1:0]  prog_period,
  input  logic [Nperiod-1:0]  prog_ticks,
  input  logic [Ntag-1:0]     prog_tag,
  input  logic                prog_v,
  output logic                prog_a,
  output logic [Ntag-1:0]     out_tag,
  output logic [Nct-1:0]      out_ct,
  output logic                out_v,
  input  logic                out_a,
  output logic [15:0]         overrun_count
);

  localparam int NumGens = 2**Ngens;
  localparam int EntryW  = 2*Nperiod + Ntag;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    EMIT   = 2'd3
  } state_t;

  state_t             state_r, state_s, adv_state_s;
  logic [Ngens-1:0]   idx_r, idx_s, adv_idx_s;
  logic [EntryW-1:0]  mem_r [NumGens];
  logic [EntryW-1:0]  rd_data_r;
  logic [Nperiod-1:0] rd_period_s, rd_ticks_s;
  logic [Ntag-1:0]    rd_tag_s;
  logic               wr_en_s;
  logic [Ngens-1:0]   wr_addr_s;
  logic [EntryW-1:0]  wr_data_s;
  logic               emit_load_s;

  assign {rd_period_s, rd_ticks_s, rd_tag_s} = rd_data_r;

  // Next-state, storage write port and programming handshake decode
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    wr_en_s     = 1'b0;
    wr_addr_s   = idx_r;
    wr_data_s   = rd_data_r;
    emit_load_s = 1'b0;
    prog_a      = 1'b0;
    // Where to go once the current generator is finished; gens_used is live
    if (idx_r >= gens_used) begin
      adv_state_s = IDLE;
      adv_idx_s   = idx_r;
    end else begin
      adv_state_s = READ;
      adv_idx_s   = idx_r + Ngens'(1);
    end
    case (state_r)
      IDLE: begin
        if (time_unit_pulse) begin
          idx_s   = '0;
          state_s = READ;
        end else if (prog_v && reset) begin
          prog_a    = 1'b1;
          wr_en_s   = 1'b1;
          wr_addr_s = prog_gen_idx;
          wr_data_s = {prog_period, prog_ticks, prog_tag};
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        state_s = UPDATE;
      end
      UPDATE: begin
        if (!gens_en[idx_r] || rd_period_s == '0) begin
          state_s = adv_state_s;
          idx_s   = adv_idx_s;
        end else if (rd_ticks_s > Nperiod'(1)) begin
          wr_en_s   = 1'b1;
          wr_data_s = {rd_period_s, rd_ticks_s - Nperiod'(1), rd_tag_s};
          state_s   = adv_state_s;
          idx_s     = adv_idx_s;
        end else begin
          // ticks of 0 or 1 both fire, so the countdown never wraps
          wr_en_s     = 1'b1;
          wr_data_s   = {rd_period_s, rd_period_s, rd_tag_s};
          emit_load_s = 1'b1;
          state_s     = EMIT;
        end
      end
      EMIT: begin
        if (out_a) begin
          state_s = adv_state_s;
          idx_s   = adv_idx_s;
        end else begin
          state_s = EMIT;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = '0;
      end
    endcase
  end

  // FSM state, sweep index and registered spike output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      idx_r   <= '0;
      out_v   <= 1'b0;
      out_tag <= '0;
      out_ct  <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      out_v   <= (state_s == EMIT);
      if (emit_load_s) begin
        out_tag <= rd_tag_s;
        out_ct  <= Nct'(1);
      end
    end
  end

  // Generator storage with registered read; contents survive reset by design
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
    if (state_r == READ) begin
      rd_data_r <= mem_r[idx_r];
    end
  end

`ifdef SPIKE_GEN_OVERRUN_CNT_EN
  logic        pulse_drop_s;
  logic [15:0] overrun_r;

  assign pulse_drop_s = time_unit_pulse && (state_r != IDLE);

  // Saturating count of time pulses lost because a sweep was still running
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_r <= 16'h0000;
    end else if (pulse_drop_s && overrun_r != 16'hFFFF) begin
      overrun_r <= overrun_r + 16'h0001;
    end
  end

  assign overrun_count = overrun_r;
`else
  assign overrun_count = 16'h0000;
`endif

endmodule

// File: tb/tb_spike_gen_sequencer.sv
// Randomised self-checking bench for spike_gen_sequencer against a per-generator countdown model.
module tb_spike_gen_sequencer;
  localparam int Ngens   = 8;
  localparam int Nperiod = 16;
  localparam int Ntag    = 11;
  localparam int Nct     = 10;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                time_unit_pulse = 1'b0;
  logic [Ngens-1:0]    gens_used = '0;
  logic [2**Ngens-1:0] gens_en = '0;
  logic [Ngens-1:0]    prog_gen_idx = '0;
  logic [Nperiod-1:0]  prog_period = '0;
  logic [Nperiod-1:0]  prog_ticks = '0;
  logic [Ntag-1:0]     prog_tag = '0;
  logic                prog_v = 1'b0;
  logic                prog_a;
  logic [Ntag-1:0]     out_tag;
  logic [Nct-1:0]      out_ct;
  logic                out_v;
  logic                out_a = 1'b0;
  logic [15:0]         overrun_count;

  int checks = 0;
  int errors = 0;
  int m_period [8];
  int m_ticks  [8];
  int m_tag    [8];
  int exp_q [$];
  int exp_overrun = 0;

  spike_gen_sequencer #(.Ngens(Ngens), .Nperiod(Nperiod), .Ntag(Ntag), .Nct(Nct)) dut (
    .clk(clk), .reset(reset), .time_unit_pulse(time_unit_pulse),
    .gens_used(gens_used), .gens_en(gens_en),
    .prog_gen_idx(prog_gen_idx), .prog_period(prog_period), .prog_ticks(prog_ticks),
    .prog_tag(prog_tag), .prog_v(prog_v), .prog_a(prog_a),
    .out_tag(out_tag), .out_ct(out_ct), .out_v(out_v), .out_a(out_a),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One time unit of the reference: every enabled, non-zero-period generator counts down
  task automatic model_sweep();
    for (int g = 0; g <= int'(gens_used); g++) begin
      if (gens_en[g] && m_period[g] != 0) begin
        if (m_ticks[g] <= 1) begin
          exp_q.push_back(m_tag[g]);
          m_ticks[g] = m_period[g];
        end else begin
          m_ticks[g] = m_ticks[g] - 1;
        end
      end
    end
  endtask

  task automatic program_gen(input int g, input int p, input int t, input int tg);
    prog_gen_idx = Ngens'(g);
    prog_period  = Nperiod'(p);
    prog_ticks   = Nperiod'(t);
    prog_tag     = Ntag'(tg);
    prog_v       = 1'b1;
    #1;
    checks++;
    if (prog_a !== 1'b1) begin
      errors++;
      $display("FAIL prog_ack_idle gen %0d: prog_a=%b expected 1", g, prog_a);
    end
    step();
    prog_v = 1'b0;
    m_period[g] = p;
    m_ticks[g]  = t;
    m_tag[g]    = tg;
  endtask

  // Follow the sweep, acking spikes at random, until it has been quiet long enough to be over
  task automatic drain(input int ack_pct, output int got);
    int quiet;
    int cyc;
    quiet = 0;
    cyc   = 0;
    got   = 0;
    while (quiet < 2 * (int'(gens_used) + 1) + 4) begin
      if (cyc >= 3000) begin
        checks++;
        errors++;
        $display("FAIL sweep_timeout: no quiet window after %0d cycles, expected sweep end", cyc);
        break;
      end
      if (out_v === 1'b1) begin
        quiet = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_spike: tag=%h ct=%0d, expected no spike", out_tag, out_ct);
          out_a = 1'b1;
        end else begin
          if (out_tag !== Ntag'(exp_q[0]) || out_ct !== Nct'(1)) begin
            errors++;
            $display("FAIL spike_payload: tag=%h ct=%0d, expected tag=%h ct=1", out_tag, out_ct, Ntag'(exp_q[0]));
          end
          if ($urandom_range(99, 0) < ack_pct) begin
            out_a = 1'b1;
            void'(exp_q.pop_front());
            got++;
          end else begin
            out_a = 1'b0;
          end
        end
      end else begin
        out_a = 1'b0;
        quiet++;
      end
      cyc++;
      step();
    end
    out_a = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_spike: %0d spikes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_sweep(input int ack_pct, output int got);
    model_sweep();
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    drain(ack_pct, got);
  endtask

  task automatic test_reset();
    prog_v = 1'b1;
    #2 reset = 1'b0;
    step();
    step();
    checks++;
    if (out_v !== 1'b0 || prog_a !== 1'b0 || out_tag !== '0 || out_ct !== '0 || overrun_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: v=%b pa=%b tag=%h ct=%0d ovr=%0d, expected all 0",
               out_v, prog_a, out_tag, out_ct, overrun_count);
    end
    prog_v = 1'b0;
    reset  = 1'b1;
    step();
    for (int g = 0; g < 8; g++) program_gen(g, 0, 0, 0);
  endtask

  task automatic test_periodic();
    int got;
    gens_used = 8'd3;
    gens_en = '0;
    gens_en[3] = 1'b1;
    program_gen(3, 4, 2, 'h155);
    for (int p = 1; p <= 10; p++) begin
      run_sweep(100, got);
      checks++;
      if (got != ((p == 2 || p == 6 || p == 10) ? 1 : 0)) begin
        errors++;
        $display("FAIL periodic pulse %0d: spikes=%0d expected %0d", p, got, (p == 2 || p == 6 || p == 10) ? 1 : 0);
      end
    end
  endtask

  task automatic test_emit_stall();
    gens_used = 8'd1;
    gens_en = '0;
    gens_en[1:0] = 2'b11;
    program_gen(0, 1, 1, 'h0A5);
    program_gen(1, 1, 1, 'h3C3);
    model_sweep();
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_v !== 1'b1 || out_tag !== Ntag'(exp_q[0]) || out_ct !== Nct'(1)) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: v=%b tag=%h ct=%0d, expected v=1 tag=%h ct=1",
                 i, out_v, out_tag, out_ct, Ntag'(exp_q[0]));
      end
      if (i == 4) out_a = 1'b1;
      step();
    end
    out_a = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (out_v !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: out_v=%b expected 0", out_v);
    end
    step();
    checks++;
    if (out_v !== 1'b0) begin
      errors++;
      $display("FAIL resume_update: out_v=%b expected 0", out_v);
    end
    step();
    checks++;
    if (out_v !== 1'b1 || out_tag !== Ntag'(exp_q[0])) begin
      errors++;
      $display("FAIL resume_gen1: v=%b tag=%h expected v=1 tag=%h", out_v, out_tag, Ntag'(exp_q[0]));
    end
    out_a = 1'b1;
    step();
    out_a = 1'b0;
    void'(exp_q.pop_front());
    repeat (4) step();
  endtask

  task automatic test_prog_during_sweep();
    int got;
    gens_used = 8'd3;
    gens_en = '0;
    model_sweep();
    prog_gen_idx = 8'd2;
    prog_period  = 16'd3;
    prog_ticks   = 16'd1;
    prog_tag     = 11'h2B4;
    prog_v = 1'b1;
    time_unit_pulse = 1'b1;
    #1;
    checks++;
    if (prog_a !== 1'b0) begin
      errors++;
      $display("FAIL pulse_priority: prog_a=%b expected 0", prog_a);
    end
    step();
    time_unit_pulse = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (prog_a !== 1'b0 || out_v !== 1'b0) begin
        errors++;
        $display("FAIL prog_blocked cycle %0d: prog_a=%b out_v=%b expected 0 0", k, prog_a, out_v);
      end
      step();
    end
    checks++;
    if (prog_a !== 1'b1) begin
      errors++;
      $display("FAIL prog_first_idle: prog_a=%b expected 1", prog_a);
    end
    step();
    prog_v = 1'b0;
    m_period[2] = 3;
    m_ticks[2]  = 1;
    m_tag[2]    = 'h2B4;
    gens_en[2] = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      run_sweep(70, got);
      checks++;
      if (got != ((p == 1 || p == 4) ? 1 : 0)) begin
        errors++;
        $display("FAIL prog_written pulse %0d: spikes=%0d expected %0d", p, got, (p == 1 || p == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_overrun();
    int got;
    gens_used = 8'd3;
    gens_en = '0;
    gens_en[0] = 1'b1;
    program_gen(0, 1, 1, 'h111);
    model_sweep();
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    step();
    step();
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    drain(100, got);
    checks++;
    if (got != 1) begin
      errors++;
      $display("FAIL overrun_one_sweep: spikes=%0d expected 1", got);
    end
`ifdef SPIKE_GEN_OVERRUN_CNT_EN
    exp_overrun++;
`endif
    checks++;
    if (overrun_count !== 16'(exp_overrun)) begin
      errors++;
      $display("FAIL overrun_count: got %0d expected %0d", overrun_count, exp_overrun);
    end
  endtask

  task automatic test_disabled();
    int got;
    gens_used = 8'd5;
    gens_en = '0;
    gens_en[4] = 1'b1;
    program_gen(4, 0, 3, 'h044);
    program_gen(5, 5, 2, 'h055);
    for (int p = 1; p <= 5; p++) begin
      run_sweep(100, got);
      checks++;
      if (got != 0) begin
        errors++;
        $display("FAIL disabled pulse %0d: spikes=%0d expected 0", p, got);
      end
    end
    gens_en[5] = 1'b1;
    for (int p = 1; p <= 2; p++) begin
      run_sweep(100, got);
      checks++;
      if (got != ((p == 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL ticks_preserved pulse %0d: spikes=%0d expected %0d", p, got, (p == 2) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid_emit();
    int got;
    gens_used = 8'd1;
    gens_en = '0;
    gens_en[1:0] = 2'b11;
    program_gen(0, 1, 1, 'h301);
    program_gen(1, 1, 1, 'h302);
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    step();
    step();
    checks++;
    if (out_v !== 1'b1) begin
      errors++;
      $display("FAIL emit_reached: out_v=%b expected 1", out_v);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (out_v !== 1'b0 || out_tag !== '0 || out_ct !== '0 || overrun_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_emit: v=%b tag=%h ct=%0d ovr=%0d expected all 0", out_v, out_tag, out_ct, overrun_count);
    end
    step();
    reset = 1'b1;
    exp_overrun = 0;
    program_gen(0, 1, 1, 'h301);
    model_sweep();
    time_unit_pulse = 1'b1;
    step();
    time_unit_pulse = 1'b0;
    step();
    step();
    checks++;
    if (out_v !== 1'b1 || out_tag !== 11'h301) begin
      errors++;
      $display("FAIL restart_idx0: v=%b tag=%h expected v=1 tag=301", out_v, out_tag);
    end
    drain(100, got);
    checks++;
    if (got != 2) begin
      errors++;
      $display("FAIL restart_sweep: spikes=%0d expected 2", got);
    end
  endtask

  task automatic test_random();
    int got;
    for (int r = 0; r < 6; r++) begin
      gens_used = 8'($urandom_range(7, 0));
      gens_en = '0;
      gens_en[7:0] = 8'($urandom);
      for (int g = 0; g < 8; g++) begin
        program_gen(g, int'($urandom_range(5, 0)), int'($urandom_range(5, 0)), int'($urandom_range(2047, 0)));
      end
      for (int s = 0; s < 8; s++) run_sweep(int'($urandom_range(100, 30)), got);
    end
    checks++;
    if (overrun_count !== 16'(exp_overrun)) begin
      errors++;
      $display("FAIL overrun_after_random: got %0d expected %0d", overrun_count, exp_overrun);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_emit_stall();
    test_prog_during_sweep();
    test_overrun();
    test_disabled();
    test_reset_mid_emit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_gen_sequencer.md
SPIKE_GEN_SEQUENCER -- requirements
Module: spike_gen_sequencer

Interface
REQ-001 Parameters SHALL be: Ngens, default 8, generator index width, giving 2**Ngens generators; Nperiod, default 16, period/tick width; Ntag, default 11, tag width; Nct, default 10, count width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 time_unit_pulse  input  1  one-cycle strobe, one per FPGA wall-clock time unit.
REQ-005 gens_used  input  Ngens  highest generator index swept.
REQ-006 gens_en  input  2**Ngens  per-generator enable.
REQ-007 prog_gen_idx / prog_period / prog_ticks / prog_tag  input  Ngens / Nperiod / Nperiod / Ntag  generator programming payload.
REQ-008 prog_v  input  1; prog_a  output  1  programming valid/ack handshake.
REQ-009 out_tag / out_ct  output  Ntag / Nct  emitted spike tag and count.
REQ-010 out_v  output  1; out_a  input  1  spike output valid/ack handshake.
REQ-011 overrun_count  output  16  count of dropped time pulses (see Configuration).

Function
REQ-012 Storage SHALL be one entry per generator holding {period, ticks_remaining, tag}, with a 1-cycle read latency.
REQ-013 FSM states SHALL be IDLE, READ, UPDATE, EMIT.
REQ-014 IDLE: time_unit_pulse SHALL set idx=0 and move to READ; pulse has priority over a pending prog_v in the same cycle.
REQ-015 IDLE with no pulse and prog_v=1: prog_a SHALL be 1 in that cycle, and the entry at prog_gen_idx SHALL be written with {prog_period, prog_ticks, prog_tag} on that edge.
REQ-016 prog_a SHALL be 0 in every state other than IDLE, and in IDLE during a pulse cycle.
REQ-017 READ: the FSM SHALL issue a read of entry idx and go to UPDATE on the next cycle.
REQ-018 UPDATE, gens_en[idx]=0 or period=0: the entry SHALL be left unchanged, with no emit.
REQ-019 UPDATE, enabled, period!=0, ticks_remaining>1: the FSM SHALL write ticks_remaining-1, with no emit.
REQ-020 UPDATE, enabled, period!=0, ticks_remaining<=1: the FSM SHALL write ticks_remaining=period, latch out_tag=tag and out_ct=1, and go to EMIT.
REQ-021 EMIT: out_v SHALL be held at 1 with stable payload until the first cycle with out_a=1; that cycle SHALL end EMIT.
REQ-022 After UPDATE with no emit, or after EMIT completes: if idx==gens_used, the FSM SHALL go to IDLE; otherwise it SHALL increment idx and go to READ.
REQ-023 out_v SHALL be 0 in every state other than EMIT.
REQ-024 Sweep latency SHALL be 2 cycles per generator plus the EMIT wait cycles.
REQ-025 A time_unit_pulse arriving outside IDLE SHALL be dropped and SHALL NOT restart or extend the sweep.
REQ-026 Decrement arithmetic SHALL be unsigned Nperiod-bit and SHALL never wrap below 0, because 0 and 1 both trigger reload.
REQ-027 gens_used and gens_en SHALL be sampled live at each UPDATE; no latching.

Reset
REQ-028 Asserting reset SHALL, asynchronously: put the FSM in IDLE, set idx=0, and drive out_v=0, prog_a=0, out_tag=0, out_ct=0 and overrun_count=0.
REQ-029 Generator storage contents SHALL NOT be cleared by reset; the host SHALL reprogram after reset.
REQ-030 Reset mid-EMIT SHALL drop the pending spike with no partial handshake.

Configuration
REQ-031 With SPIKE_GEN_OVERRUN_CNT_EN defined, each dropped pulse (REQ-025) SHALL increment overrun_count, saturating at 16'hFFFF.
REQ-032 Without SPIKE_GEN_OVERRUN_CNT_EN, overrun_count SHALL be constant 0 and no counter logic SHALL be synthesized.

Verification
REQ-033 The bench SHALL cover: program gen 3 with period=4, ticks=2, tag=0x155; gens_used=3; gens_en[3]=1; pulses 1..10 -> spikes with tag 0x155, ct=1 after pulses 2, 6 and 10 only.
REQ-034 The bench SHALL cover: gen 0 with period=1, out_a held low for 5 cycles -> out_v high with stable payload for 5 cycles, then the sweep resumes to gen 1.
REQ-035 The bench SHALL cover: prog_v asserted during a sweep -> prog_a=0 until IDLE, and the write completes in the first IDLE non-pulse cycle.
REQ-036 The bench SHALL cover: second pulse at sweep cycle 3, macro defined -> overrun_count=1 and exactly one sweep; macro undefined -> overrun_count=0.
REQ-037 The bench SHALL cover: gen with period=0, or gens_en bit 0, over 5 pulses -> no spikes and ticks_remaining unchanged.
REQ-038 The bench SHALL cover: reset asserted during EMIT -> out_v=0 immediately, FSM in IDLE, and the next pulse restarts at idx=0.
